sd_io_arbiter: RTL and testbench

Shares the single MiSTer sector-I/O channel (io_lba/io_rd/io_wr/io_ack plus the sd_buff port) between up to NREQ sector requesters: SCSI targets behind the NCR5380, with room for a floppy or CD-ROM unit later. It replaces the BSY-based muxing in the SCSI controller with explicit round-robin arbitration. A grant is held for a whole sector transaction. A watchdog recovers from a host that never acknowledges.

---
 rtl/sd_io_arbiter.sv | 147 ++++++++++++++
 tb/tb_sd_io_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sd_io_arbiter.sv
// Round-robin arbiter sharing the host sector-I/O channel between requesters.
// A grant spans one full sector transaction; a watchdog aborts unacked requests.
module sd_io_arbiter #(
  parameter int          NREQ    = 2,
  parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [32*NREQ-1:0]   req_lba,
  input  logic [16*NREQ-1:0]   req_buff_din,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      req_buff_wr,
  output logic [NREQ-1:0]      req_err,
  output logic [31:0]          io_lba,
  output logic [NREQ-1:0]      io_rd,
  output logic [NREQ-1:0]      io_wr,
  input  logic                 io_ack,
  input  logic                 sd_buff_wr,
  output logic [15:0]          sd_buff_din,
  output logic                 busy,
  output logic [1:0]           grant_id
);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      rr_q, rr_d;
  logic [31:0]     lba_q, lba_d;
  logic            op_rd_q, op_rd_d;
  logic [23:0]     wd_q, wd_d;
  logic [NREQ-1:0] err_q, err_d;

  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] gnt_oh;
  logic [2:0]      cand;
  logic [1:0]      pick;
  logic [1:0]      rr_inc;
  logic            found;
  logic            pick_rd;
  logic [31:0]     lba_sel;

  // First pending requester at or above rr_q, wrapping at NREQ
  always_comb begin
    pend    = req_rd | req_wr;
    pick    = rr_q;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_q} + 3'(k);
      if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
      if (!found && pend[cand[1:0]]) begin
        found = 1'b1;
        pick  = cand[1:0];
      end
    end
    lba_sel = '0;
    pick_rd = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == 2'(i)) begin
        lba_sel = req_lba[32*i +: 32];
        pick_rd = req_rd[i];
      end
    end
    rr_inc = (grant_q == 2'(NREQ-1)) ? 2'd0 : grant_q + 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      lba_q   <= '0;
      op_rd_q <= 1'b0;
      wd_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      lba_q   <= lba_d;
      op_rd_q <= op_rd_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    lba_d   = lba_q;
    op_rd_d = op_rd_q;
    wd_d    = wd_q;
    err_d   = '0;
    unique case (state_q)
      IDLE: begin
        wd_d = '0;
        if (found) begin
          state_d = GRANT;
          grant_d = pick;
          lba_d   = lba_sel;
          op_rd_d = pick_rd;
        end
      end
      GRANT: begin
        // An ack landing on the expiry cycle still wins
        if (io_ack) begin
          state_d = XFER;
        end else if (wd_q == TIMEOUT - 24'd1) begin
          state_d = IDLE;
          rr_d    = rr_inc;
          err_d   = gnt_oh;
        end else begin
          wd_d = wd_q + 24'd1;
        end
      end
      XFER: begin
        if (!io_ack) begin
          state_d = DONE;
          rr_d    = rr_inc;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) gnt_oh[i] = (grant_q == 2'(i));
    busy        = (state_q == GRANT) || (state_q == XFER);
    io_rd       = (state_q == GRANT && op_rd_q) ? gnt_oh : '0;
    io_wr       = (state_q == GRANT && !op_rd_q) ? gnt_oh : '0;
    req_ack     = (busy && io_ack) ? gnt_oh : '0;
    req_buff_wr = (busy && sd_buff_wr) ? gnt_oh : '0;
    sd_buff_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (busy && gnt_oh[i]) sd_buff_din = req_buff_din[16*i +: 16];
    end
    req_err  = err_q;
    io_lba   = lba_q;
    grant_id = grant_q;
  end

endmodule

// File: tb/tb_sd_io_arbiter.sv
// Directed bench for sd_io_arbiter: read, round robin, write mux,
// watchdog abort, rd/wr conflict, stray ack and async reset.
module tb_sd_io_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_rd, req_wr;
  logic [63:0] req_lba;
  logic [31:0] req_buff_din;
  logic [1:0]  req_ack, req_buff_wr, req_err;
  logic [31:0] io_lba;
  logic [1:0]  io_rd, io_wr;
  logic        io_ack, sd_buff_wr;
  logic [15:0] sd_buff_din;
  logic        busy;
  logic [1:0]  grant_id;

  int nvec = 0;
  int nerr = 0;

  sd_io_arbiter #(.NREQ(2), .TIMEOUT(24'd16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_lba      (req_lba),
    .req_buff_din (req_buff_din),
    .req_ack      (req_ack),
    .req_buff_wr  (req_buff_wr),
    .req_err      (req_err),
    .io_lba       (io_lba),
    .io_rd        (io_rd),
    .io_wr        (io_wr),
    .io_ack       (io_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    int good;
    int hi;
    int errs;
    logic [1:0] exp_g;
    reset = 1'b1;
    req_rd = '0; req_wr = '0; req_lba = '0; req_buff_din = '0;
    io_ack = 1'b0; sd_buff_wr = 1'b0;
    tick; tick;
    check("rst_io_rd", 32'(io_rd), 32'h0);
    check("rst_io_wr", 32'(io_wr), 32'h0);
    check("rst_lba", io_lba, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h0);
    check("rst_err", 32'(req_err), 32'h0);
    check("rst_din", 32'(sd_buff_din), 32'h0);
    reset = 1'b0;

    // single read from requester 1
    req_rd = 2'b10;
    req_lba[63:32] = 32'h1234;
    tick;
    check("rd_strobe", 32'(io_rd), 32'h2);
    check("rd_lba", io_lba, 32'h1234);
    check("rd_grant", 32'(grant_id), 32'h1);
    check("rd_busy", 32'(busy), 32'h1);
    req_rd = 2'b00;
    req_lba[63:32] = 32'hFFFF;
    io_ack = 1'b1;
    #1 check("rd_ack_route", 32'(req_ack), 32'h2);
    tick;
    check("rd_strobe_drop", 32'(io_rd), 32'h0);
    check("rd_lba_hold", io_lba, 32'h1234);
    check("rd_xfer_busy", 32'(busy), 32'h1);
    good = 0;
    for (int i = 0; i < 256; i++) begin
      sd_buff_wr = 1'b1;
      #2 if (req_buff_wr == 2'b10) good++;
      @(posedge clk);
      #1 sd_buff_wr = 1'b0;
      #1 if (req_buff_wr == 2'b00) good++;
      tick;
    end
    check("rd_buff_wr_route", 32'(good), 32'd512);
    io_ack = 1'b0;
    tick;
    check("rd_done_busy", 32'(busy), 32'h0);
    tick;
    check("rd_idle_busy", 32'(busy), 32'h0);

    // round robin with both requesters held
    req_rd = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_g = 2'(t % 2);
      tick;
      check("rr_grant", 32'(grant_id), 32'(exp_g));
      check("rr_strobe", 32'(io_rd), (exp_g == 2'd0) ? 32'h1 : 32'h2);
      io_ack = 1'b1;
      tick;
      check("rr_xfer_strobe", 32'(io_rd), 32'h0);
      io_ack = 1'b0;
      tick;
      check("rr_done_busy", 32'(busy), 32'h0);
      tick;
      check("rr_idle_strobe", 32'(io_rd), 32'h0);
    end
    req_rd = 2'b00;

    // write data mux from requester 0
    req_wr = 2'b01;
    req_buff_din = {16'h1111, 16'hBEEF};
    tick;
    check("wr_strobe", 32'(io_wr), 32'h1);
    check("wr_no_rd", 32'(io_rd), 32'h0);
    req_wr = 2'b00;
    io_ack = 1'b1;
    tick;
    check("wr_xfer_din", 32'(sd_buff_din), 32'hBEEF);
    io_ack = 1'b0;
    tick;
    check("wr_done_din", 32'(sd_buff_din), 32'h0);
    tick;
    check("wr_idle_din", 32'(sd_buff_din), 32'h0);

    // stray ack and buffer strobe while idle
    io_ack = 1'b1;
    sd_buff_wr = 1'b1;
    #1 check("stray_ack", 32'(req_ack), 32'h0);
    check("stray_bwr", 32'(req_buff_wr), 32'h0);
    tick;
    check("stray_busy", 32'(busy), 32'h0);
    check("stray_strobe", 32'(io_rd | io_wr), 32'h0);
    io_ack = 1'b0;
    sd_buff_wr = 1'b0;

    // read and write both set: read wins
    req_rd = 2'b01;
    req_wr = 2'b01;
    tick;
    check("conf_rd", 32'(io_rd), 32'h1);
    check("conf_wr", 32'(io_wr), 32'h0);
    req_rd = 2'b00;
    req_wr = 2'b00;
    io_ack = 1'b1;
    tick;
    io_ack = 1'b0;
    tick; tick;

    // watchdog abort on requester 0
    req_rd = 2'b01;
    tick;
    check("to_strobe", 32'(io_rd), 32'h1);
    hi = 1;
    errs = 0;
    for (int c = 0; c < 40 && errs == 0; c++) begin
      tick;
      if (io_rd[0]) hi++;
      if (req_err[0]) errs++;
    end
    check("to_err_seen", 32'(errs), 32'd1);
    check("to_strobe_cycles", 32'(hi), 32'd16);
    check("to_err_strobe_low", 32'(io_rd), 32'h0);
    check("to_err_vec", 32'(req_err), 32'h1);
    req_rd = 2'b11;
    tick;
    check("to_err_single", 32'(req_err), 32'h0);
    check("to_next_grant", 32'(grant_id), 32'h1);
    check("to_next_strobe", 32'(io_rd), 32'h2);

    // async reset in the middle of a transfer
    io_ack = 1'b1;
    tick;
    sd_buff_wr = 1'b1;
    #1 check("ar_pre_bwr", 32'(req_buff_wr), 32'h2);
    #2 reset = 1'b1;
    #1 check("ar_io_rd", 32'(io_rd), 32'h0);
    check("ar_io_wr", 32'(io_wr), 32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_bwr", 32'(req_buff_wr), 32'h0);
    check("ar_grant", 32'(grant_id), 32'h0);
    tick;
    io_ack = 1'b0;
    sd_buff_wr = 1'b0;
    reset = 1'b0;
    tick;
    check("ar_first_grant", 32'(grant_id), 32'h0);
    check("ar_first_strobe", 32'(io_rd), 32'h1);
    req_rd = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
